// File: rtl/count_bcd_display_pkg.sv
// Shared definitions for the count -> BCD -> 7-segment display path.
// Holds converter state encodings, active-low segment patterns ({g,f,e,d,c,b,a}),
// a vector-sizing log2 helper and the digit decoder.
package count_bcd_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Ceil(log2(value)), never less than 1 so the result can always size a vector.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // BCD nibble to active-low segments; codes above 9 are never produced upstream.
    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/count_bcd_display_if.sv
// Bus bundle between the up-counter/board side and count_bcd_display.
// No latency of its own; pure wiring.
// No backpressure: count_in is sampled freely, outputs are fire-and-forget.
//   master: drives count_in, observes the display/BCD outputs
//   slave : the display block itself
interface count_bcd_display_if #(
    parameter int N      = 4,
    parameter int DIGITS = 4
);
    logic [N-1:0]          count_in;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  bcd_valid;
    logic                  overflow;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;

    modport master (output count_in, input bcd_out, bcd_valid, overflow, an, seg);
    modport slave  (input count_in, output bcd_out, bcd_valid, overflow, an, seg);
endinterface

// File: rtl/count_bcd_display_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, free-running IDLE/SHIFT/DONE.
// Latency: sample at edge t0, result + 1-cycle valid at t0+N+1; period N+2.
// No backpressure: input changes between samples are ignored, results simply overwrite.
//   ports: clk, reset (async, active-low), count_in[N], bcd[4*DIGITS], valid, overflow
module bin2bcd_seq
    import count_bcd_display_pkg::*;
#(
    parameter int N      = 4,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        count_in,
    output logic [4*DIGITS-1:0] bcd,
    output logic                valid,
    output logic                overflow
);
    // One spare nibble above the exported digits catches values >= 10**DIGITS.
    localparam int SW = 4*DIGITS + 4;
    localparam int IW = clog2(N + 1);

    conv_state_e          state_q, state_d;
    logic [SW-1:0]        scr_q, scr_d;
    logic [N-1:0]         bin_q, bin_d;
    logic [IW-1:0]        iter_q, iter_d;
    logic                 lost_q, lost_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic [SW-1:0]        adj;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            scr_q   <= '0;
            bin_q   <= '0;
            iter_q  <= '0;
            lost_q  <= 1'b0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            scr_q   <= scr_d;
            bin_q   <= bin_d;
            iter_q  <= iter_d;
            lost_q  <= lost_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_SHIFT;
            ST_SHIFT: if (iter_q == IW'(1)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scr_d   = scr_q;
        bin_d   = bin_q;
        iter_d  = iter_q;
        lost_d  = lost_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;

        adj = scr_q;
        for (int k = 0; k < DIGITS + 1; k++) begin
            if (scr_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
        end

        case (state_q)
            ST_IDLE: begin
                bin_d  = count_in;
                scr_d  = '0;
                lost_d = 1'b0;
                iter_d = IW'(N);
            end
            ST_SHIFT: begin
                scr_d  = {adj[SW-2:0], bin_q[N-1]};
                bin_d  = bin_q << 1;
                // A set bit leaving the scratch top means the value outgrew even the spare nibble.
                lost_d = lost_q | adj[SW-1];
                iter_d = iter_q - IW'(1);
            end
            ST_DONE: begin
                bcd_d   = scr_q[4*DIGITS-1:0];
                ovf_d   = lost_q | (scr_q[SW-1 -: 4] != 4'd0);
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bcd      = bcd_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
endmodule

// File: rtl/count_bcd_display.sv
// Counter value -> BCD -> time-multiplexed common-anode 7-segment display.
// Latency: BCD per bin2bcd_seq (N+2 period); an/seg registered, 1 clk behind index/bcd.
// No backpressure: count_in sampled each conversion period, display scans freely.
//   ports: clk, reset (async, active-low), bus (slave: count_in in; bcd_out, bcd_valid,
//          overflow, an[DIGITS] active-low one-hot, seg[7] active-low {g..a} out)
module count_bcd_display
    import count_bcd_display_pkg::*;
#(
    parameter int N        = 4,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16,
    parameter int LZB      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    count_bcd_display_if.slave    bus
);
    localparam int PW = clog2(SCAN_DIV);
    localparam int DW = clog2(DIGITS);

    logic [4*DIGITS-1:0] bcd;
    logic                bcd_vld;
    logic                ovf;

    bin2bcd_seq #(.N(N), .DIGITS(DIGITS)) u_conv (
        .clk      (clk),
        .reset    (reset),
        .count_in (bus.count_in),
        .bcd      (bcd),
        .valid    (bcd_vld),
        .overflow (ovf)
    );

    logic [PW-1:0]     pre_q, pre_d;
    logic [DW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] lead_zero;
    logic [3:0]        cur_nib;
    logic              above;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    // Scan prescaler: each digit stays selected for SCAN_DIV cycles.
    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == DW'(DIGITS - 1)) ? '0 : idx_q + DW'(1);
        end
    end

    // lead_zero[i]: nibble i and every nibble above it are zero.
    always_comb begin
        lead_zero = '0;
        above     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            above        = above & (bcd[4*i +: 4] == 4'd0);
            lead_zero[i] = above;
        end
    end

    always_comb begin
        cur_nib = 4'(bcd >> {idx_q, 2'b00});
        an_d    = ~(DIGITS'(1) << idx_q);
        if (ovf)
            seg_d = SEG_DASH;
        else if ((LZB != 0) && (idx_q != '0) && lead_zero[idx_q])
            seg_d = SEG_BLANK;
        else
            seg_d = seg_of(cur_nib);
    end

    assign bus.bcd_out   = bcd;
    assign bus.bcd_valid = bcd_vld;
    assign bus.overflow  = ovf;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
endmodule

// File: tb/tb_count_bcd_display.sv
// Directed bench for count_bcd_display across five parameter sets sharing clk/reset.
// Table-driven value/segment checks plus hand-written reset, latency and scan sequences.
module tb_count_bcd_display;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S5 = 7'h12;
    localparam logic [6:0] S7 = 7'h78, S9 = 7'h10, SB = 7'h7F, SD = 7'h3F;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] cnt4 = 4'd9;
    logic [7:0] cnt8 = 8'd0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    count_bcd_display_if #(.N(4), .DIGITS(4)) b0 ();
    count_bcd_display_if #(.N(8), .DIGITS(3)) b1 ();
    count_bcd_display_if #(.N(8), .DIGITS(2)) b2 ();
    count_bcd_display_if #(.N(4), .DIGITS(2)) b3 ();
    count_bcd_display_if #(.N(4), .DIGITS(4)) b4 ();

    assign b0.count_in = cnt4;
    assign b3.count_in = cnt4;
    assign b4.count_in = cnt4;
    assign b1.count_in = cnt8;
    assign b2.count_in = cnt8;

    count_bcd_display #(.N(4), .DIGITS(4), .SCAN_DIV(16), .LZB(1)) u0 (.clk(clk), .reset(reset), .bus(b0));
    count_bcd_display #(.N(8), .DIGITS(3), .SCAN_DIV(16), .LZB(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    count_bcd_display #(.N(8), .DIGITS(2), .SCAN_DIV(16), .LZB(1)) u2 (.clk(clk), .reset(reset), .bus(b2));
    count_bcd_display #(.N(4), .DIGITS(2), .SCAN_DIV(4),  .LZB(1)) u3 (.clk(clk), .reset(reset), .bus(b3));
    count_bcd_display #(.N(4), .DIGITS(4), .SCAN_DIV(16), .LZB(0)) u4 (.clk(clk), .reset(reset), .bus(b4));

    typedef struct {
        logic [7:0]  cnt;
        logic [11:0] bcd3;
        logic        ovf3;
        logic [7:0]  bcd2;
        logic        ovf2;
    } vec8_t;

    typedef struct {
        logic [3:0]      cnt;
        logic [15:0]     bcd;
        logic [3:0][6:0] seg_lzb;
        logic [3:0][6:0] seg_all;
    } vec4_t;

    vec8_t v8 [8];
    vec4_t v4 [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Edges until the selected DUT shows bcd_valid (sampled at negedge); -1 on timeout.
    task automatic wait_valid(input int which, output int edges);
        logic v;
        edges = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk);
            @(negedge clk);
            v = (which == 0) ? b0.bcd_valid : b1.bcd_valid;
            if (v) begin
                edges = e;
                break;
            end
        end
    endtask

    initial begin
        int e, f0, f1, bad;
        logic [3:0] one4;
        logic [1:0] one2;
        logic [3:0][6:0] got0, got4;
        logic [1:0][6:0] got2;

        one4 = 4'b0001;
        one2 = 2'b01;

        v8[0] = '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0};
        v8[1] = '{8'd7,   12'h007, 1'b0, 8'h07, 1'b0};
        v8[2] = '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0};
        v8[3] = '{8'd100, 12'h100, 1'b0, 8'h00, 1'b1};
        v8[4] = '{8'd255, 12'h255, 1'b0, 8'h55, 1'b1};
        v8[5] = '{8'd128, 12'h128, 1'b0, 8'h28, 1'b1};
        v8[6] = '{8'd42,  12'h042, 1'b0, 8'h42, 1'b0};
        v8[7] = '{8'd10,  12'h010, 1'b0, 8'h10, 1'b0};

        v4[0] = '{4'd7,  16'h0007, {SB, SB, SB, S7}, {S0, S0, S0, S7}};
        v4[1] = '{4'd0,  16'h0000, {SB, SB, SB, S0}, {S0, S0, S0, S0}};
        v4[2] = '{4'd15, 16'h0015, {SB, SB, S1, S5}, {S0, S0, S1, S5}};
        v4[3] = '{4'd10, 16'h0010, {SB, SB, S1, S0}, {S0, S0, S1, S0}};
        v4[4] = '{4'd12, 16'h0012, {SB, SB, S1, S2}, {S0, S0, S1, S2}};

        // Reset state
        #1 reset = 1'b0;
        #2;
        chk("rst_bcd",   32'(b0.bcd_out),   32'h0);
        chk("rst_valid", 32'(b0.bcd_valid), 32'h0);
        chk("rst_ovf",   32'(b0.overflow),  32'h0);
        chk("rst_an",    32'(b0.an),        32'hF);
        chk("rst_seg",   32'(b0.seg),       32'h7F);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // First-valid latency and scan sequence from release
        f0 = 0;
        f1 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (b0.bcd_valid && f0 == 0) f0 = k;
            if (b1.bcd_valid && f1 == 0) f1 = k;
            chk($sformatf("scan_an_k%0d", k), 32'(b3.an),
                32'((((k - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01));
        end
        chk("first_valid_n4", 32'(f0), 32'd6);
        chk("first_valid_n8", 32'(f1), 32'd10);

        // Reset mid-SHIFT
        repeat (2) @(negedge clk);
        chk("pre_abort_bcd", 32'(b0.bcd_out), 32'h0009);
        reset = 1'b0;
        #1;
        chk("abort_bcd",   32'(b0.bcd_out),   32'h0);
        chk("abort_valid", 32'(b0.bcd_valid), 32'h0);
        chk("abort_an",    32'(b0.an),        32'hF);
        chk("abort_seg",   32'(b0.seg),       32'h7F);
        chk("abort_an_d2", 32'(b3.an),        32'h3);
        @(negedge clk);
        reset = 1'b1;
        wait_valid(0, e);
        chk("abort_first_valid", 32'(e), 32'd6);
        chk("abort_first_bcd", 32'(b0.bcd_out), 32'h0009);

        // 255 held on N=8: value and valid period
        cnt8 = 8'd255;
        wait_valid(1, e);
        wait_valid(1, e);
        wait_valid(1, e);
        chk("n8_period", 32'(e), 32'd10);
        wait_valid(1, e);
        chk("n8_period2", 32'(e), 32'd10);
        chk("n8_255_bcd", 32'(b1.bcd_out), 32'h255);
        chk("n8_255_ovf", 32'(b1.overflow), 32'h0);

        // N=8 value table across DIGITS=3 and DIGITS=2
        foreach (v8[i]) begin
            cnt8 = v8[i].cnt;
            repeat (25) @(negedge clk);
            chk($sformatf("d3_bcd_%0d", v8[i].cnt), 32'(b1.bcd_out),  32'(v8[i].bcd3));
            chk($sformatf("d3_ovf_%0d", v8[i].cnt), 32'(b1.overflow), 32'(v8[i].ovf3));
            chk($sformatf("d2_bcd_%0d", v8[i].cnt), 32'(b2.bcd_out),  32'(v8[i].bcd2));
            chk($sformatf("d2_ovf_%0d", v8[i].cnt), 32'(b2.overflow), 32'(v8[i].ovf2));
        end

        // Overflow shows dashes; 99 shows digits
        for (int pass = 0; pass < 2; pass++) begin
            cnt8 = (pass == 0) ? 8'd100 : 8'd99;
            repeat (25) @(negedge clk);
            got2 = '0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                for (int d = 0; d < 2; d++)
                    if (b2.an == ~(one2 << d)) got2[d] = b2.seg;
            end
            chk($sformatf("d2_segs_%0d", cnt8), 32'(got2),
                (pass == 0) ? 32'({SD, SD}) : 32'({S9, S9}));
        end

        // N=4 segment table, leading-zero blanking on and off
        foreach (v4[i]) begin
            cnt4 = v4[i].cnt;
            repeat (14) @(negedge clk);
            got0 = '0;
            got4 = '0;
            bad = 0;
            for (int c = 0; c < 70; c++) begin
                @(negedge clk);
                for (int d = 0; d < 4; d++) begin
                    if (b0.an == ~(one4 << d)) got0[d] = b0.seg;
                    if (b4.an == ~(one4 << d)) got4[d] = b4.seg;
                end
                if ($countones(~b0.an) != 1) bad++;
            end
            chk($sformatf("n4_bcd_%0d", v4[i].cnt),     32'(b0.bcd_out), 32'(v4[i].bcd));
            chk($sformatf("n4_seg_lzb_%0d", v4[i].cnt), 32'(got0), 32'(v4[i].seg_lzb));
            chk($sformatf("n4_seg_all_%0d", v4[i].cnt), 32'(got4), 32'(v4[i].seg_all));
            chk($sformatf("n4_onehot_%0d", v4[i].cnt),  32'(bad), 32'd0);
        end

        // count_in change during SHIFT is ignored until the next sample
        cnt4 = 4'd5;
        repeat (14) @(negedge clk);
        wait_valid(0, e);
        @(posedge clk);
        @(negedge clk);
        cnt4 = 4'd9;
        wait_valid(0, e);
        chk("mid_shift_lat", 32'(e), 32'd5);
        chk("mid_shift_old", 32'(b0.bcd_out), 32'h0005);
        wait_valid(0, e);
        chk("mid_shift_new", 32'(b0.bcd_out), 32'h0009);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
